pe_array_feeder: RTL and testbench
==================================

// Module: pe_array_feeder
// PURPOSE
//  Sequencer driving the 32x32 PE array for one coding block (CB) integer search.
//  Pulls current-CB pixels and reference rows from upstream valid/ready streams, loads them into the
//  PE array, issues compute strobes, and hands each candidate result to the SAD adder tree via cand_valid/sad_ready.
// PARAMETERS
//  PIXEL        8   bits per pixel
//  X            32  PE array columns (pixels per row)
//  Y            32  PE array rows
//  SHIFT_BEATS  8   8-row reference shift beats after the initial fill; candidates per CB = SHIFT_BEATS+1
// PORTS
//  clk                clk   input   1         single clock, rising edge
//  rst                input   1               asynchronous, active-high reset
//  start              input   1               1-cycle pulse; begins one CB; ignored unless IDLE
//  cb_sel             input   1               sampled with start; driven on CB_select for whole CB
//  cur_data           input   2*X*PIXEL       two current rows (512 b)
//  cur_valid          input   1               cur_data valid
//  cur_ready          output  1               feeder accepts cur_data
//  ref_data           input   8*X*PIXEL       eight reference rows (2048 b)
//  ref_valid          input   1               ref_data valid
//  ref_ready          output  1               feeder accepts ref_data
//  current_64pixels   output  2*X*PIXEL       to PE array
//  in_curr_enable     output  1               current-row load strobe to PE array
//  CB_select          output  1               to PE array
//  ref_8R_32          output  8*X*PIXEL       to PE array
//  change_ref         output  1               reference load/shift strobe to PE array
//  ref_input_Control  output  1               1 = parallel fill, 0 = shift-in 8 rows
//  abs_Control        output  2               00 idle/hold, 01 compute; 10/11 never driven
//  cand_valid         output  1               abs_outs of PE array hold candidate cand_idx
//  cand_idx           output  4               candidate index 0..SHIFT_BEATS
//  sad_ready          input   1               adder tree consumed candidate
//  busy               output  1               high from start accept until done
//  done               output  1               1-cycle pulse after last candidate handshake
// BEHAVIOUR
//  Reset: all outputs 0 (data buses included), state IDLE, counters 0; reset mid-CB abandons it, no done.
//  All PE-array outputs registered; beat accepted at edge N appears on PE-array ports in cycle N+1 only.
//  States: IDLE -> LOAD_CUR -> LOAD_REF -> COMPUTE -> WAIT -> (SHIFT -> COMPUTE -> WAIT)* -> DONE -> IDLE.
//  IDLE: cur_ready=ref_ready=0; start latches cb_sel, busy=1 next cycle, -> LOAD_CUR.
//  LOAD_CUR: cur_ready=1; each cur_valid&&cur_ready loads 2 rows, in_curr_enable=1 for 1 cycle;
//   Y/2=16 beats, row pair index 0..15 top-down; after beat 15 -> LOAD_REF. Gaps in cur_valid: strobe 0, bus held.
//  LOAD_REF: ref_ready=1; each accepted beat: change_ref=1, ref_input_Control=1 for 1 cycle; Y/8=4 beats -> COMPUTE.
//  COMPUTE: single cycle, abs_Control=01 (entered once last load/shift strobe has been presented); -> WAIT.
//  WAIT: cand_valid=1, cand_idx=candidate count, held until sad_ready; on handshake:
//   if cand_idx==SHIFT_BEATS -> DONE else -> SHIFT, count+1.
//  SHIFT: ref_ready=1; accepted beat: change_ref=1, ref_input_Control=0 for 1 cycle -> COMPUTE.
//  One candidate in flight max: no ref beat accepted while cand_valid=1 (abs_outs never overwritten).
//  DONE: done=1 one cycle, busy=0 next cycle, -> IDLE. start in same cycle as done is ignored.
//  Outside strobe cycles: in_curr_enable, change_ref=0, abs_Control=00; data buses hold last value.
//  cur_ready=0 outside LOAD_CUR; ref_ready=0 outside LOAD_REF/SHIFT; extra upstream beats never consumed.
//  Latency, zero stalls, sad_ready=1: start to done = 1+16+4+2*(SHIFT_BEATS+1)+2*SHIFT_BEATS+1 cycles.
// TESTING
//  Reset then start, cb_sel=1, all valids/ready high -> CB_select=1, 16 in_curr_enable, 4 fills, 9 cand_valid idx 0..8, done once.
//  cur_data beat k = {64{k}} (k=0..15) -> current_64pixels shows 8'h00..8'h0F in order, one cycle per strobe.
//  sad_ready low 5 cycles at cand_idx=3 -> cand_valid/idx held, ref_ready=0, no change_ref until release.
//  ref_valid toggled 1/0 during SHIFT -> change_ref only on accepted beats, ref_input_Control=0 there, 1 for first 4.
//  start pulsed while busy and in DONE cycle -> ignored; no second CB begins.
//  rst asserted during WAIT at idx=5 -> all outputs 0 immediately, IDLE, no done; next start runs full CB.

Source files
------------

// File: rtl/pe_array_feeder.sv
// ============================================================================
// pe_array_feeder
// ----------------------------------------------------------------------------
// Sequencer that feeds a 32x32 PE array for the integer search of one coding
// block (CB). It pulls current-CB rows and reference rows from two upstream
// valid/ready streams, loads them into the PE array, fires compute strobes
// and hands each candidate result to the SAD adder tree.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, cb_sel       1-cycle start pulse (IDLE only) and CB select sample
//   cur_data/valid/ready  current-row stream, two rows per beat
//   ref_data/valid/ready  reference stream, eight rows per beat
//   current_64pixels, in_curr_enable   current-row bus and load strobe
//   CB_select           CB select held for the whole block
//   ref_8R_32, change_ref, ref_input_Control  reference bus, strobe, mode
//   abs_Control         00 hold, 01 compute
//   cand_valid, cand_idx, sad_ready   candidate handshake with adder tree
//   busy, done          block in progress / 1-cycle completion pulse
// ============================================================================
module pe_array_feeder #(
    parameter int PIXEL       = 8,
    parameter int X           = 32,
    parameter int Y           = 32,
    parameter int SHIFT_BEATS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cb_sel,
    input  logic [2*X*PIXEL-1:0]   cur_data,
    input  logic                   cur_valid,
    output logic                   cur_ready,
    input  logic [8*X*PIXEL-1:0]   ref_data,
    input  logic                   ref_valid,
    output logic                   ref_ready,
    output logic [2*X*PIXEL-1:0]   current_64pixels,
    output logic                   in_curr_enable,
    output logic                   CB_select,
    output logic [8*X*PIXEL-1:0]   ref_8R_32,
    output logic                   change_ref,
    output logic                   ref_input_Control,
    output logic [1:0]             abs_Control,
    output logic                   cand_valid,
    output logic [3:0]             cand_idx,
    input  logic                   sad_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int CUR_BEATS = Y / 2;
    localparam int REF_BEATS = Y / 8;
    localparam int CC_W      = $clog2(CUR_BEATS + 1);
    localparam int RC_W      = $clog2(REF_BEATS + 1);

    localparam logic [CC_W-1:0] CUR_LAST  = CC_W'(CUR_BEATS - 1);
    localparam logic [RC_W-1:0] REF_LAST  = RC_W'(REF_BEATS - 1);
    localparam logic [3:0]      CAND_LAST = 4'(SHIFT_BEATS);

    // SETTLE is the cycle in which the last load/shift strobe is presented
    // to the array; COMPUTE follows so the array always sees settled rows.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CUR,
        S_LOAD_REF,
        S_SETTLE,
        S_COMPUTE,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CC_W-1:0]   cur_cnt;
    logic [RC_W-1:0]   ref_cnt;
    logic [3:0]        cand_cnt;
    logic              cur_acc;
    logic              ref_acc;

    // Ready is a pure function of state, so no ref beat can land while a
    // candidate is waiting in WAIT.
    assign cur_ready  = (state == S_LOAD_CUR);
    assign ref_ready  = (state == S_LOAD_REF) || (state == S_SHIFT);
    assign cur_acc    = cur_valid && cur_ready;
    assign ref_acc    = ref_valid && ref_ready;
    assign cand_valid = (state == S_WAIT);
    assign cand_idx   = cand_cnt;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (start) state_nxt = S_LOAD_CUR;
            S_LOAD_CUR: if (cur_acc && cur_cnt == CUR_LAST) state_nxt = S_LOAD_REF;
            S_LOAD_REF: if (ref_acc && ref_cnt == REF_LAST) state_nxt = S_SETTLE;
            S_SETTLE:   state_nxt = S_COMPUTE;
            S_COMPUTE:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (sad_ready) state_nxt = (cand_cnt == CAND_LAST) ? S_DONE : S_SHIFT;
            end
            S_SHIFT:    if (ref_acc) state_nxt = S_SETTLE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            cur_cnt           <= '0;
            ref_cnt           <= '0;
            cand_cnt          <= '0;
            CB_select         <= 1'b0;
            current_64pixels  <= '0;
            in_curr_enable    <= 1'b0;
            ref_8R_32         <= '0;
            change_ref        <= 1'b0;
            ref_input_Control <= 1'b0;
            abs_Control       <= 2'b00;
        end else begin
            state <= state_nxt;

            // Array-facing strobes are registered: a beat accepted at one
            // edge is presented for exactly the following cycle.
            in_curr_enable    <= cur_acc;
            change_ref        <= ref_acc;
            ref_input_Control <= ref_acc && (state == S_LOAD_REF);
            abs_Control       <= (state_nxt == S_COMPUTE) ? 2'b01 : 2'b00;

            if (cur_acc) current_64pixels <= cur_data;
            if (ref_acc) ref_8R_32 <= ref_data;

            if (state == S_IDLE && start) begin
                CB_select <= cb_sel;
                cur_cnt   <= '0;
                ref_cnt   <= '0;
                cand_cnt  <= '0;
            end else begin
                if (cur_acc) cur_cnt <= cur_cnt + CC_W'(1);
                if (ref_acc && state == S_LOAD_REF) ref_cnt <= ref_cnt + RC_W'(1);
                if (state == S_WAIT && sad_ready && cand_cnt != CAND_LAST)
                    cand_cnt <= cand_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// ============================================================================
// tb_pe_array_feeder
// ----------------------------------------------------------------------------
// Scoreboard bench: stimulus pushes the expected array-side response for each
// beat it hands over; a negedge monitor pops and compares whenever the DUT
// presents a strobe, a candidate or done.
// ============================================================================
module tb_pe_array_feeder;

    localparam int PIXEL = 8;
    localparam int X     = 32;
    localparam int Y     = 32;
    localparam int SB    = 8;
    localparam int CW    = 2 * X * PIXEL;
    localparam int RW    = 8 * X * PIXEL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, cb_sel, cur_valid, ref_valid, sad_ready;
    logic [CW-1:0] cur_data;
    logic [RW-1:0] ref_data;
    logic          cur_ready, ref_ready, in_curr_enable, CB_select;
    logic          change_ref, ref_input_Control, cand_valid, busy, done;
    logic [CW-1:0] current_64pixels;
    logic [RW-1:0] ref_8R_32;
    logic [1:0]    abs_Control;
    logic [3:0]    cand_idx;

    pe_array_feeder #(.PIXEL(PIXEL), .X(X), .Y(Y), .SHIFT_BEATS(SB)) dut (
        .clk(clk), .rst(rst), .start(start), .cb_sel(cb_sel),
        .cur_data(cur_data), .cur_valid(cur_valid), .cur_ready(cur_ready),
        .ref_data(ref_data), .ref_valid(ref_valid), .ref_ready(ref_ready),
        .current_64pixels(current_64pixels), .in_curr_enable(in_curr_enable),
        .CB_select(CB_select), .ref_8R_32(ref_8R_32), .change_ref(change_ref),
        .ref_input_Control(ref_input_Control), .abs_Control(abs_Control),
        .cand_valid(cand_valid), .cand_idx(cand_idx), .sad_ready(sad_ready),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [CW-1:0] exp_cur_q[$];
    logic [RW:0]   exp_ref_q[$];
    int            exp_cand_q[$];
    int            exp_done_q[$];
    logic          exp_cb = 1'b0;
    int            exp_lat = -1;
    int            start_cyc = 0;
    int            done_cnt = 0;
    int            compute_cnt = 0;
    bit            stall_en = 1'b0;
    bit            spam = 1'b0;
    bit            abort = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_ev(input string name, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s actual=%s expected=%s", name, act, exp);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [CW-1:0] mc;
        logic [RW:0]   mr;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (in_curr_enable) begin
                    if (exp_cur_q.size() == 0) fail_ev("cur_strobe", "strobe", "none");
                    else begin
                        mc = exp_cur_q.pop_front();
                        checks++;
                        if (current_64pixels !== mc) begin
                            errors++;
                            $display("FAIL cur_bus actual=%0h expected=%0h",
                                     current_64pixels[63:0], mc[63:0]);
                        end
                    end
                end
                if (change_ref) begin
                    if (exp_ref_q.size() == 0) fail_ev("ref_strobe", "strobe", "none");
                    else begin
                        mr = exp_ref_q.pop_front();
                        chk("ref_ctl", ref_input_Control, mr[RW]);
                        checks++;
                        if (ref_8R_32 !== mr[RW-1:0]) begin
                            errors++;
                            $display("FAIL ref_bus actual=%0h expected=%0h",
                                     ref_8R_32[63:0], mr[63:0]);
                        end
                    end
                end
                if (cand_valid) begin
                    chk("ref_ready_in_wait", ref_ready, 1'b0);
                    chk("change_ref_in_wait", change_ref, 1'b0);
                    chk("cb_select", CB_select, exp_cb);
                    if (exp_cand_q.size() == 0) fail_ev("cand", "cand_valid", "none");
                    else begin
                        chk("cand_idx", cand_idx, exp_cand_q[0]);
                        if (sad_ready) void'(exp_cand_q.pop_front());
                    end
                end
                if (abs_Control != 2'b00) begin
                    chk("abs_code", abs_Control, 2'b01);
                    compute_cnt++;
                end
                if (done) begin
                    if (exp_done_q.size() == 0) fail_ev("done", "pulse", "none");
                    else begin
                        void'(exp_done_q.pop_front());
                        if (exp_lat >= 0) chk("latency", cyc - start_cyc, exp_lat);
                    end
                    done_cnt++;
                end
            end
        end
    end

    // ---------------- adder-tree side ----------------
    initial begin
        int sc;
        sc = 0;
        sad_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_en) begin
                sc = 0;
                sad_ready = 1'b1;
            end else if (cand_valid && cand_idx == 4'd3 && sc < 5) begin
                sad_ready = 1'b0;
                sc++;
            end else begin
                sad_ready = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_cur(input bit gaps);
        int k = 0;
        int n = 0;
        while (k < 16 && n < 400 && !abort) begin
            cur_data  = {64{8'(k)}};
            cur_valid = gaps ? (n % 2 == 0) : 1'b1;
            if (cur_valid && cur_ready) begin
                exp_cur_q.push_back({64{8'(k)}});
                k++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        cur_valid = 1'b1;
        cur_data  = {64{8'hEE}};
    endtask

    task automatic drive_ref(input bit gaps);
        int j = 0;
        int n = 0;
        while (j < 4 + SB && n < 400 && !abort) begin
            ref_data  = {256{8'h80 + 8'(j)}};
            ref_valid = gaps ? (n % 2 == 0) : 1'b1;
            if (ref_valid && ref_ready) begin
                exp_ref_q.push_back({(j < 4), {256{8'h80 + 8'(j)}}});
                j++;
            end
            @(posedge clk);
            #1;
            n++;
        end
        ref_valid = 1'b1;
        ref_data  = {256{8'hEE}};
    endtask

    task automatic tail(input int d0);
        int n = 0;
        while (done_cnt == d0 && !abort && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            start = spam & busy;
        end
        if (!abort && done_cnt == d0) fail_ev("done_wait", "timeout", "done");
        start = 1'b0;
    endtask

    task automatic watch(input int idx, input int d0);
        int n = 0;
        if (idx >= 0) begin
            while (!(cand_valid && cand_idx == 4'(idx)) && done_cnt == d0 && n < 400) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (cand_valid && cand_idx == 4'(idx)) begin
                #2;
                rst = 1'b1;
                #1;
                chk("abort_flags", {cur_ready, ref_ready, in_curr_enable, CB_select, change_ref,
                                    ref_input_Control, abs_Control, cand_valid, cand_idx,
                                    busy, done}, '0);
                chk("abort_cur_bus", |current_64pixels, 1'b0);
                chk("abort_ref_bus", |ref_8R_32, 1'b0);
                abort = 1'b1;
            end else begin
                fail_ev("abort_point", "missing", "cand_idx");
            end
        end
    endtask

    task automatic run_cb(input logic sel, input bit gaps, input bit stall, input bit sp,
                          input int lat, input int abort_idx);
        int d0 = done_cnt;
        cur_valid = 1'b0;
        ref_valid = 1'b0;
        stall_en  = stall;
        spam      = sp;
        exp_cb    = sel;
        exp_lat   = lat;
        for (int i = 0; i <= SB; i++) exp_cand_q.push_back(i);
        exp_done_q.push_back(1);
        start     = 1'b1;
        cb_sel    = sel;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cb_sel = ~sel;
        chk("busy_after_start", busy, 1'b1);
        fork
            drive_cur(gaps);
            drive_ref(gaps);
            tail(d0);
            watch(abort_idx, d0);
        join
        stall_en = 1'b0;
        spam     = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cb_sel = 1'b0;
        cur_valid = 1'b0;
        ref_valid = 1'b0;
        cur_data = '0;
        ref_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {cur_ready, ref_ready, in_curr_enable, CB_select, change_ref,
                            ref_input_Control, abs_Control, cand_valid, cand_idx, busy, done}, '0);
        chk("reset_cur_bus", |current_64pixels, 1'b0);
        chk("reset_ref_bus", |ref_8R_32, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean block, cb_sel=1, every stream always ready.
        run_cb(1'b1, 1'b0, 1'b0, 1'b0, 56, -1);
        repeat (3) @(posedge clk);
        #1;

        // Gapped streams, stall at candidate 3, start held high while busy and in DONE.
        run_cb(1'b0, 1'b1, 1'b1, 1'b1, -1, -1);
        repeat (5) @(posedge clk);
        #1;
        chk("no_restart_busy", busy, 1'b0);
        chk("no_restart_cur_ready", cur_ready, 1'b0);

        // Reset while waiting on candidate 5.
        run_cb(1'b1, 1'b0, 1'b0, 1'b0, -1, 5);
        repeat (4) @(posedge clk);
        #1;
        exp_cur_q.delete();
        exp_ref_q.delete();
        exp_cand_q.delete();
        exp_done_q.delete();
        rst = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_abort", busy, 1'b0);
        chk("no_done_after_abort", done_cnt, 2);

        // Full block after the abandoned one.
        run_cb(1'b0, 1'b0, 1'b0, 1'b0, 56, -1);
        repeat (5) @(posedge clk);
        #1;

        chk("cur_left", exp_cur_q.size(), 0);
        chk("ref_left", exp_ref_q.size(), 0);
        chk("cand_left", exp_cand_q.size(), 0);
        chk("done_left", exp_done_q.size(), 0);
        chk("compute_total", compute_cnt, 33);
        chk("done_total", done_cnt, 3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
